store_buffer: RTL and testbench
===============================

# store_buffer

In-order FIFO of committed stores sitting between the commit stage and the data memory (`memd`). It is the write-side counterpart to the core's memd read path. Commit pushes one store per cycle. The buffer drains entries in order to memd through a valid/ready write port. A combinational lookup port lets in-flight loads see stores that are buffered but not yet written.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of two and at least 2.
- `ADDR_W`, 4: store address width; matches `MEMD_SIZE_LOG`.
- `DATA_W`, 16: store data width; matches `REG_LEN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assertion, active-low.
- `st_valid`  in  1  commit presents a store.
- `st_ready`  out  1  buffer can accept a store; equals `!full`.
- `st_addr`  in  ADDR_W  store address.
- `st_data`  in  DATA_W  store data.
- `mem_wvalid`  out  1  head entry is valid and presented to memd.
- `mem_wready`  in  1  memd accepts the write this cycle.
- `mem_waddr`  out  ADDR_W  head entry address.
- `mem_wdata`  out  DATA_W  head entry data.
- `ld_addr`  in  ADDR_W  load lookup address (combinational).
- `ld_hit`  out  1  a buffered store matches `ld_addr`; forwarding build only.
- `ld_data`  out  DATA_W  data of the youngest matching entry.
- `ld_conflict`  out  1  a matching entry exists and cannot be forwarded.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `empty`  out  1  `count == 0`.
- `full`  out  1  `count == DEPTH`.

## Operation
- State:
  - circular array of {addr, data} plus a per-entry valid bit;
  - `head` and `tail` pointers, each $clog2(DEPTH) bits;
  - `count` register.
- Enqueue occurs when `st_valid && st_ready`:
  - write the entry at `tail`;
  - set its valid bit;
  - increment `tail`, wrapping modulo DEPTH.
- Dequeue occurs when `mem_wvalid && mem_wready`:
  - clear the valid bit at `head`;
  - increment `head`, wrapping modulo DEPTH.
- `count` update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged when both or neither occur.
- Drain outputs:
  - `mem_wvalid` = valid bit at `head`.
  - `mem_waddr`/`mem_wdata` come directly from the head entry and hold stable while `mem_wvalid && !mem_wready`.
  - When the buffer is empty, `mem_waddr`/`mem_wdata` are don't-care.
- Lookup:
  - compare `ld_addr` against every valid entry;
  - the youngest match is the one closest to `tail - 1`, searching backwards toward `head`.
  - A store enqueued this cycle is not visible to the lookup.
  - `ld_data` is 0 when there is no match.
- Stores are never squashed. The buffer holds only committed stores, so the core's squash does not touch it.

## Timing
- Reset (`rst` low), asynchronously:
  - all valid bits, `head`, `tail` and `count` go to 0;
  - `empty`=1, `full`=0, `st_ready`=1, `mem_wvalid`=0, `ld_hit`=0, `ld_conflict`=0, `ld_data`=0.
- Reset mid-operation drops all buffered stores. No memd write is issued in the reset cycle.
- Enqueue-to-drain latency: an entry pushed at edge N drives `mem_wvalid` in cycle N+1. There is no same-cycle bypass, even when the buffer is empty.
- Throughput: one enqueue and one dequeue per cycle, sustained.
- Full: `st_ready`=0 even if a dequeue happens in the same cycle (no full-bypass). The push is accepted the next cycle.
- Empty: simultaneous `st_valid` and `mem_wready` leaves count at 1 after the edge, because nothing drains.
- Wrap-around: the pointer after DEPTH-1 is 0. Youngest-match priority follows age, not index.
- Lookup outputs are purely combinational from current state and `ld_addr`.

## Configuration
- `STORE_BUFFER_FWD_EN` defined (forwarding build):
  - `ld_hit`=1 on any match;
  - `ld_data` = youngest matching data;
  - `ld_conflict`=0 always.
- `STORE_BUFFER_FWD_EN` undefined (conflict-only build):
  - `ld_hit`=0 and `ld_data`=0 always;
  - `ld_conflict`=1 on any match; the core must stall the load until the store drains.

## Test plan
- Reset then push {addr 3, data 0x00AA} with `mem_wready`=0:
  - next cycle `mem_wvalid`=1, `mem_waddr`=3, `mem_wdata`=0x00AA, `count`=1;
  - outputs stable over 5 stall cycles.
- Fill DEPTH=4 with `mem_wready`=0:
  - `full`=1 and `st_ready`=0;
  - assert `mem_wready` and `st_valid` together: one drain, no push, `count`=3;
  - the push is accepted the following cycle.
- Push addr 5/0x0011 then addr 5/0x0022, then look up `ld_addr`=5:
  - FWD build: `ld_hit`=1, `ld_data`=0x0022;
  - non-FWD build: `ld_conflict`=1, `ld_hit`=0.
- Wrap-around:
  - run 10 push/drain pairs at 1 per cycle;
  - memd sees addr/data in exact push order;
  - the youngest-match check after wrap returns the newest data.
- Push 0x0010 to addr 7, drain it, then look up addr 7: `ld_hit`=0 and `ld_conflict`=0.
- Drop `rst` asynchronously mid-clock with 3 entries:
  - `empty`=1 and `mem_wvalid`=0 immediately;
  - no memd write occurs.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores draining to memd, with a load lookup port.
// Optional macro STORE_BUFFER_FWD_EN selects store-to-load forwarding instead of conflict-only lookup.
`default_nettype none

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     mem_wvalid,
    input  logic                     mem_wready,
    output logic [ADDR_W-1:0]        mem_waddr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_data,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  cnt;
    logic              enq;
    logic              deq;
    logic              match_any;
    logic [PTR_W-1:0]  idx;
`ifdef STORE_BUFFER_FWD_EN
    logic [DATA_W-1:0] match_data;
`endif

    assign full       = (cnt == CNT_W'(DEPTH));
    assign empty      = (cnt == '0);
    assign st_ready   = !full;
    assign count      = cnt;
    assign enq        = st_valid && st_ready;
    assign mem_wvalid = valid[head];
    assign deq        = mem_wvalid && mem_wready;
    assign mem_waddr  = addr_mem[head];
    assign mem_wdata  = data_mem[head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
        end else begin
            // head and tail only coincide when full or empty, where one side is blocked
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= st_addr;
            data_mem[tail] <= st_data;
        end
    end

    // Walk from oldest (head) to youngest so the last match found wins.
    always_comb begin
        match_any = 1'b0;
        idx       = head;
`ifdef STORE_BUFFER_FWD_EN
        match_data = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (valid[idx] && (addr_mem[idx] == ld_addr)) begin
                match_any = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
                match_data = data_mem[idx];
`endif
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    assign ld_hit      = match_any;
    assign ld_data     = match_data;
    assign ld_conflict = 1'b0;
`else
    assign ld_hit      = 1'b0;
    assign ld_data     = '0;
    assign ld_conflict = match_any;
`endif

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer with a queue-based reference model and drain scoreboard.
`default_nettype none

module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [3:0]  st_addr = '0;
    logic [15:0] st_data = '0;
    logic        mem_wvalid;
    logic        mem_wready = 1'b0;
    logic [3:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [3:0]  ld_addr = '0;
    logic        ld_hit;
    logic [15:0] ld_data;
    logic        ld_conflict;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int compared   = 0;
    int mismatched = 0;

    ent_t mdl[$];
    ent_t exp_q[$];
    logic        p_v  = 1'b0;
    logic        p_wr = 1'b0;
    ent_t        p_e;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drain scoreboard: every accepted memd write must match the oldest issued store.
    always @(negedge clk) begin
        if (rst && mem_wvalid && mem_wready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL spurious_write: got addr 0x%0h data 0x%0h expected none", mem_waddr, mem_wdata);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("drain_addr", 32'(mem_waddr), 32'(e.a));
                chk("drain_data", 32'(mem_wdata), 32'(e.d));
            end
        end
    end

    task automatic apply_prev();
        bit acc;
        bit dq;
        acc = p_v && (mdl.size() < DEPTH);
        dq  = p_wr && (mdl.size() > 0);
        if (dq)  void'(mdl.pop_front());
        if (acc) mdl.push_back(p_e);
    endtask

    task automatic check_state();
        bit          hit;
        logic [15:0] d;
        chk("count",      32'(count),      32'(mdl.size()));
        chk("empty",      32'(empty),      32'(mdl.size() == 0));
        chk("full",       32'(full),       32'(mdl.size() == DEPTH));
        chk("st_ready",   32'(st_ready),   32'(mdl.size() < DEPTH));
        chk("mem_wvalid", 32'(mem_wvalid), 32'(mdl.size() > 0));
        if (mdl.size() > 0) begin
            chk("head_addr", 32'(mem_waddr), 32'(mdl[0].a));
            chk("head_data", 32'(mem_wdata), 32'(mdl[0].d));
        end
        hit = 1'b0;
        d   = '0;
        for (int i = mdl.size() - 1; i >= 0; i--) begin
            if (mdl[i].a == ld_addr) begin
                hit = 1'b1;
                d   = mdl[i].d;
                break;
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        chk("ld_hit",      32'(ld_hit),      32'(hit));
        chk("ld_data",     32'(ld_data),     32'(d));
        chk("ld_conflict", 32'(ld_conflict), 32'(0));
`else
        chk("ld_hit",      32'(ld_hit),      32'(0));
        chk("ld_data",     32'(ld_data),     32'(0));
        chk("ld_conflict", 32'(ld_conflict), 32'(hit));
`endif
    endtask

    task automatic step(input logic v, input logic [3:0] a, input logic [15:0] d,
                        input logic wr, input logic [3:0] la);
        @(posedge clk);
        #1;
        apply_prev();
        st_valid   = v;
        st_addr    = a;
        st_data    = d;
        mem_wready = wr;
        ld_addr    = la;
        if (v && (mdl.size() < DEPTH)) exp_q.push_back({a, d});
        p_v  = v;
        p_wr = wr;
        p_e  = {a, d};
        #1;
        check_state();
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 4'h0, 16'h0, 1'b1, 4'h0);
    endtask

    initial begin
        #12;
        chk("rst_empty",      32'(empty),       32'(1));
        chk("rst_full",       32'(full),        32'(0));
        chk("rst_st_ready",   32'(st_ready),    32'(1));
        chk("rst_mem_wvalid", 32'(mem_wvalid),  32'(0));
        chk("rst_ld_hit",     32'(ld_hit),      32'(0));
        chk("rst_ld_conflict",32'(ld_conflict), 32'(0));
        chk("rst_ld_data",    32'(ld_data),     32'(0));
        chk("rst_count",      32'(count),       32'(0));
        @(negedge clk);
        rst = 1'b1;

        // Single push held under stall
        step(1'b1, 4'd3, 16'h00AA, 1'b0, 4'd3);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 16'h0, 1'b0, 4'd3);
        drain_all();

        // Fill, then push+drain while full: push refused, accepted next cycle
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'(i + 8), 16'(16'h0100 + i), 1'b0, 4'd9);
        step(1'b1, 4'd1, 16'h0BAD, 1'b1, 4'd1);
        step(1'b1, 4'd1, 16'h0BEE, 1'b0, 4'd1);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd1);
        drain_all();

        // Youngest match on duplicate address
        step(1'b1, 4'd5, 16'h0011, 1'b0, 4'd5);
        step(1'b1, 4'd5, 16'h0022, 1'b0, 4'd5);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd5);
        drain_all();

        // Wrap-around at one push and one drain per cycle, then duplicate after wrap
        for (int i = 0; i < 10; i++) step(1'b1, 4'(i), 16'(16'h0A00 + i), 1'b1, 4'(i));
        step(1'b1, 4'd6, 16'h0E01, 1'b0, 4'd6);
        step(1'b1, 4'd6, 16'h0E02, 1'b0, 4'd6);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd6);
        drain_all();

        // Drained entry no longer visible
        step(1'b1, 4'd7, 16'h0010, 1'b0, 4'd7);
        step(1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd7);

        // Asynchronous reset with three entries buffered
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 2), 16'(16'h0C00 + i), 1'b0, 4'd2);
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd2);
        @(posedge clk);
        #1;
        apply_prev();
        p_v = 1'b0;
        p_wr = 1'b0;
        mem_wready = 1'b1;
        #2;
        rst = 1'b0;
        mdl.delete();
        exp_q.delete();
        #1;
        chk("arst_empty",      32'(empty),      32'(1));
        chk("arst_mem_wvalid", 32'(mem_wvalid), 32'(0));
        chk("arst_count",      32'(count),      32'(0));
        chk("arst_conflict",   32'(ld_conflict),32'(0));
        @(negedge clk);
        @(negedge clk);
        #1;
        mem_wready = 1'b0;
        rst = 1'b1;
        step(1'b0, 4'd0, 16'h0, 1'b0, 4'd2);

        // Randomized traffic over a narrow address range to exercise matches
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 5)),
                 16'($urandom), 1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)));
        end
        drain_all();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
